// File: rtl/pong_graph_if.sv
// Pixel-stream bundle between the sync timing stage and the Pong pixel generator.
// The master is the timing/display side; the slave is pong_graph.
interface pong_graph_if;
    logic        p_tick;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [11:0] rgb;
    logic        miss;

    modport master (
        output p_tick, video_on, pixel_x, pixel_y,
        input  rgb, miss
    );

    modport slave (
        input  p_tick, video_on, pixel_x, pixel_y,
        output rgb, miss
    );
endinterface

// File: rtl/pong_graph.sv
// Pong pixel generator: wall, right paddle and square ball over a switch-selected
// background, with game state advanced once per frame on the refresh tick.
module pong_graph #(
    parameter int BALL_SIZE    = 8,
    parameter int BALL_V       = 2,
    parameter int PAD_H        = 72,
    parameter int PAD_V        = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic         clk,
    input  logic         rst,
    pong_graph_if.slave  vid,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic [11:0]  bg_color
);
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0] WALL_L    = 10'd32;
    localparam logic [9:0] WALL_R    = 10'd35;
    localparam logic [9:0] WALL_HIT  = 10'd36;
    localparam logic [9:0] PAD_L     = 10'd600;
    localparam logic [9:0] PAD_R     = 10'd603;
    localparam logic [9:0] X_EXIT    = 10'd639;
    localparam logic [9:0] SERVE_X   = 10'd316;
    localparam logic [9:0] SERVE_Y   = 10'd236;
    localparam logic [9:0] PAD_INIT  = 10'd204;
    localparam logic [9:0] BS_M1     = 10'(BALL_SIZE - 1);
    localparam logic [9:0] BV        = 10'(BALL_V);
    localparam logic [9:0] PH_M1     = 10'(PAD_H - 1);
    localparam logic [9:0] PV        = 10'(PAD_V);
    localparam logic [9:0] BALL_YMAX = 10'(480 - BALL_V - BALL_SIZE);
    localparam logic [9:0] PAD_YMAX  = 10'(479 - PAD_V - PAD_H);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_t;

    state_t           r_state, w_state_nxt;
    logic [9:0]       r_bx, r_by, r_pad_top;
    logic [9:0]       w_bx_nxt, w_by_nxt, w_pad_nxt;
    logic             r_vx_neg, r_vy_neg, w_vx_neg_nxt, w_vy_neg_nxt;
    logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
    logic [11:0]      r_rgb, w_rgb_nxt;

    logic       w_refr_tick;
    logic [9:0] w_ball_r, w_ball_b, w_pad_bot;
    logic       w_pad_hit, w_on_ball, w_on_pad, w_on_wall;

    assign w_refr_tick = vid.p_tick && (vid.pixel_x == 10'd0) && (vid.pixel_y == 10'd481);
    assign w_ball_r    = r_bx + BS_M1;
    assign w_ball_b    = r_by + BS_M1;
    assign w_pad_bot   = r_pad_top + PH_M1;
    assign w_pad_hit   = (w_ball_r >= PAD_L) && (w_ball_r <= PAD_R)
                      && (w_ball_b >= r_pad_top) && (r_by <= w_pad_bot);

    // NOTE: every w_*_nxt gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt     = r_state;
        w_bx_nxt        = r_bx;
        w_by_nxt        = r_by;
        w_vx_neg_nxt    = r_vx_neg;
        w_vy_neg_nxt    = r_vy_neg;
        w_frame_cnt_nxt = r_frame_cnt;
        w_pad_nxt       = r_pad_top;

        case (r_state)
            SERVE: begin
                if (w_refr_tick) begin
                    if (r_frame_cnt == CNT_LAST) begin
                        w_frame_cnt_nxt = '0;
                        w_state_nxt     = PLAY;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (w_refr_tick) begin
                    if (w_ball_r >= X_EXIT) begin
                        w_state_nxt = MISS;
                    end else begin
                        // Bounds are tested before moving, so a left/up step never underflows.
                        if (r_by <= BV)             w_vy_neg_nxt = 1'b0;
                        else if (r_by >= BALL_YMAX) w_vy_neg_nxt = 1'b1;
                        if (r_bx <= WALL_HIT)       w_vx_neg_nxt = 1'b0;
                        else if (w_pad_hit)         w_vx_neg_nxt = 1'b1;
                        w_bx_nxt = w_vx_neg_nxt ? (r_bx - BV) : (r_bx + BV);
                        w_by_nxt = w_vy_neg_nxt ? (r_by - BV) : (r_by + BV);
                    end
                end
            end
            MISS: begin
                w_state_nxt  = SERVE;
                w_bx_nxt     = SERVE_X;
                w_by_nxt     = SERVE_Y;
                w_vx_neg_nxt = 1'b0;
                w_vy_neg_nxt = 1'b0;
            end
            default: w_state_nxt = SERVE;
        endcase

        if (w_refr_tick) begin
            if (btn_up && !btn_down && (r_pad_top >= PV))
                w_pad_nxt = r_pad_top - PV;
            else if (btn_down && !btn_up && (r_pad_top <= PAD_YMAX))
                w_pad_nxt = r_pad_top + PV;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SERVE;
            r_bx        <= SERVE_X;
            r_by        <= SERVE_Y;
            r_vx_neg    <= 1'b0;
            r_vy_neg    <= 1'b0;
            r_pad_top   <= PAD_INIT;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bx        <= w_bx_nxt;
            r_by        <= w_by_nxt;
            r_vx_neg    <= w_vx_neg_nxt;
            r_vy_neg    <= w_vy_neg_nxt;
            r_pad_top   <= w_pad_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    assign w_on_ball = (vid.pixel_x >= r_bx) && (vid.pixel_x <= w_ball_r)
                    && (vid.pixel_y >= r_by) && (vid.pixel_y <= w_ball_b);
    assign w_on_pad  = (vid.pixel_x >= PAD_L) && (vid.pixel_x <= PAD_R)
                    && (vid.pixel_y >= r_pad_top) && (vid.pixel_y <= w_pad_bot);
    assign w_on_wall = (vid.pixel_x >= WALL_L) && (vid.pixel_x <= WALL_R);

    always_comb begin
        w_rgb_nxt = bg_color;
        if (!vid.video_on)  w_rgb_nxt = 12'h000;
        else if (w_on_ball) w_rgb_nxt = 12'hF00;
        else if (w_on_pad)  w_rgb_nxt = 12'h0F0;
        else if (w_on_wall) w_rgb_nxt = 12'h00F;
    end

    always_ff @(posedge clk) begin
        if (rst)             r_rgb <= 12'h000;
        else if (vid.p_tick) r_rgb <= w_rgb_nxt;
    end

    assign vid.rgb  = r_rgb;
    assign vid.miss = (r_state == MISS);
endmodule
